// File: rtl/tcheck_pkg.sv
// Shared definitions for the setup/hold timing-check controller.
package tcheck_pkg;
    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {
        KIND_SETUP = 1'b0,
        KIND_HOLD  = 1'b1
    } kind_e;

    typedef struct packed {
        logic [$clog2(NCH_DEF)-1:0] ch;
        kind_e                      kind;
        logic [CNT_W_DEF-1:0]       delta;
    } report_t;

    // Channel-index width that stays legal for a single-channel build.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/tcheck_if.sv
// Event, configuration and violation-report signals of tcheck_ctrl.
interface tcheck_if import tcheck_pkg::*; #(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();
    localparam int CH_W = ch_width(NCH);

    logic [NCH-1:0]   ref_ev;
    logic [NCH-1:0]   dat_ev;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic             cfg_kind;
    logic [CNT_W-1:0] cfg_limit;
    logic             ovf_clr;
    logic             vio_valid;
    logic             vio_ready;
    logic [CH_W-1:0]  vio_ch;
    logic             vio_kind;
    logic [CNT_W-1:0] vio_delta;
    logic [NCH-1:0]   ovf;

    modport master (
        output ref_ev, dat_ev, cfg_we, cfg_ch, cfg_kind, cfg_limit, ovf_clr, vio_ready,
        input  vio_valid, vio_ch, vio_kind, vio_delta, ovf
    );
    modport slave (
        input  ref_ev, dat_ev, cfg_we, cfg_ch, cfg_kind, cfg_limit, ovf_clr, vio_ready,
        output vio_valid, vio_ch, vio_kind, vio_delta, ovf
    );
endinterface

// File: rtl/tcheck_chan.sv
// One check channel: separation counters, setup/hold limits, checks and a
// single pending-report slot with a sticky lost-report flag.
module tcheck_chan import tcheck_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ref_ev,
    input  logic             dat_ev,
    input  logic             we_setup,
    input  logic             we_hold,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             ovf_clr,
    input  logic             grant,
    output logic             pend,
    output logic             pend_kind,
    output logic [CNT_W-1:0] pend_delta,
    output logic             ovf
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] since_dat_reg, setup_lim_reg, hold_lim_reg, hold_cnt_reg, delta_reg;
    logic             hold_open_reg, pend_reg, ovf_reg;
    kind_e            kind_reg;

    logic [CNT_W-1:0] sep, new_delta;
    logic             hold_win, setup_vio, hold_vio, new_vio, drop;
    kind_e            new_kind;

    // A same-cycle dat_ev counts as zero separation and only ever as SETUP.
    always_comb begin
        sep       = dat_ev ? '0 : since_dat_reg;
        hold_win  = hold_open_reg && (hold_cnt_reg <= hold_lim_reg);
        setup_vio = ref_ev && (setup_lim_reg != '0) && (sep < setup_lim_reg);
        hold_vio  = dat_ev && !ref_ev && (hold_lim_reg != '0) && hold_win;
        new_vio   = setup_vio || hold_vio;
        new_kind  = hold_vio ? KIND_HOLD : KIND_SETUP;
        new_delta = hold_vio ? hold_cnt_reg : sep;
        drop      = new_vio && pend_reg && !grant;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            since_dat_reg <= CNT_MAX;
            setup_lim_reg <= '0;
            hold_lim_reg  <= '0;
            hold_cnt_reg  <= '0;
            hold_open_reg <= 1'b0;
            pend_reg      <= 1'b0;
            kind_reg      <= KIND_SETUP;
            delta_reg     <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            since_dat_reg <= (sep == CNT_MAX) ? CNT_MAX : sep + 1'b1;
            if (we_setup) setup_lim_reg <= cfg_limit;
            if (we_hold)  hold_lim_reg  <= cfg_limit;
            if (ref_ev) begin
                hold_open_reg <= 1'b1;
                hold_cnt_reg  <= CNT_W'(1);
            end else if (hold_open_reg) begin
                if (hold_cnt_reg >= hold_lim_reg) hold_open_reg <= 1'b0;
                else                              hold_cnt_reg  <= hold_cnt_reg + 1'b1;
            end
            // A grant in the same cycle frees the slot, so the new report fits.
            if (new_vio && !drop) begin
                pend_reg  <= 1'b1;
                kind_reg  <= new_kind;
                delta_reg <= new_delta;
            end else if (grant) begin
                pend_reg  <= 1'b0;
            end
            ovf_reg <= (ovf_reg && !ovf_clr) || drop;
        end
    end

    assign pend       = pend_reg;
    assign pend_kind  = kind_reg;
    assign pend_delta = delta_reg;
    assign ovf        = ovf_reg;
endmodule

// File: rtl/tcheck_ctrl.sv
// Setup/hold checker: NCH check channels feeding a round-robin arbiter and a
// registered violation-report output with valid/ready handshake.
module tcheck_ctrl import tcheck_pkg::*; #(
    parameter int NCH   = NCH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic     clk,
    input logic     rst,
    tcheck_if.slave bus
);
    localparam int CH_W = ch_width(NCH);

    logic [NCH-1:0]   pend, pend_kind, grant, ovf_bits;
    logic [CNT_W-1:0] pend_delta [NCH];
    logic [CH_W-1:0]  ptr_reg, sel, idx;
    logic             any_pend, load;
    logic             vio_valid_reg, vio_kind_reg;
    logic [CH_W-1:0]  vio_ch_reg;
    logic [CNT_W-1:0] vio_delta_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            tcheck_chan #(.CNT_W(CNT_W)) u_chan (
                .clk        (clk),
                .srst       (rst),
                .ref_ev     (bus.ref_ev[gi]),
                .dat_ev     (bus.dat_ev[gi]),
                .we_setup   (bus.cfg_we && (bus.cfg_ch == CH_W'(gi)) && !bus.cfg_kind),
                .we_hold    (bus.cfg_we && (bus.cfg_ch == CH_W'(gi)) &&  bus.cfg_kind),
                .cfg_limit  (bus.cfg_limit),
                .ovf_clr    (bus.ovf_clr),
                .grant      (grant[gi]),
                .pend       (pend[gi]),
                .pend_kind  (pend_kind[gi]),
                .pend_delta (pend_delta[gi]),
                .ovf        (ovf_bits[gi])
            );
        end
    endgenerate

    // Scan from the farthest offset down so the nearest pending channel after ptr wins.
    always_comb begin
        load     = !vio_valid_reg || bus.vio_ready;
        any_pend = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr_reg) + i) % NCH);
            if (pend[idx]) begin
                any_pend = 1'b1;
                sel      = idx;
            end
        end
        grant = '0;
        if (load && any_pend) grant[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg       <= '0;
            vio_valid_reg <= 1'b0;
            vio_ch_reg    <= '0;
            vio_kind_reg  <= 1'b0;
            vio_delta_reg <= '0;
        end else if (load) begin
            if (any_pend) begin
                vio_valid_reg <= 1'b1;
                vio_ch_reg    <= sel;
                vio_kind_reg  <= pend_kind[sel];
                vio_delta_reg <= pend_delta[sel];
                ptr_reg       <= (sel == CH_W'(NCH - 1)) ? '0 : sel + 1'b1;
            end else begin
                vio_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.vio_valid = vio_valid_reg;
    assign bus.vio_ch    = vio_ch_reg;
    assign bus.vio_kind  = vio_kind_reg;
    assign bus.vio_delta = vio_delta_reg;
    assign bus.ovf       = ovf_bits;
endmodule

// File: tb/tb_tcheck_ctrl.sv
// Bench for tcheck_ctrl: directed scenarios plus random traffic, all checked
// against a timestamp-based reference model of the checking rules.
module tb_tcheck_ctrl;
    import tcheck_pkg::*;

    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int NEVER = -100000;
    localparam int SAT   = 255;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tcheck_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();
    tcheck_ctrl #(.NCH(NCH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: event timestamps instead of counters.
    int         m_lastdat [NCH];
    int         m_lastref [NCH];
    int         m_slim    [NCH];
    int         m_hlim    [NCH];
    bit         m_pend    [NCH];
    report_t    m_slot    [NCH];
    bit [NCH-1:0] m_ovf;
    int         m_ptr;
    bit         m_valid;
    report_t    m_out;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lastdat[c] = NEVER;
            m_lastref[c] = NEVER;
            m_slim[c]    = 0;
            m_hlim[c]    = 0;
            m_pend[c]    = 1'b0;
            m_slot[c]    = '0;
        end
        m_ovf   = '0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_out   = '0;
    endtask

    task automatic model_step();
        bit      vio  [NCH];
        report_t nrep [NCH];
        bit      load;
        int      g;
        int      sep;
        int      h;
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            sep = bus.dat_ev[c] ? 0 : ((cyc - m_lastdat[c]) > SAT ? SAT : (cyc - m_lastdat[c]));
            h   = cyc - m_lastref[c];
            vio[c]  = 1'b0;
            nrep[c] = '0;
            nrep[c].ch = 2'(c);
            if (bus.ref_ev[c] && m_slim[c] != 0 && sep < m_slim[c]) begin
                vio[c] = 1'b1;
                nrep[c].kind  = KIND_SETUP;
                nrep[c].delta = 8'(sep);
            end else if (bus.dat_ev[c] && !bus.ref_ev[c] && m_hlim[c] != 0 && h >= 1 && h <= m_hlim[c]) begin
                vio[c] = 1'b1;
                nrep[c].kind  = KIND_HOLD;
                nrep[c].delta = 8'(h);
            end
        end
        load = !m_valid || bus.vio_ready;
        g = -1;
        if (load) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
        end
        if (g >= 0) begin
            m_out     = m_slot[g];
            m_valid   = 1'b1;
            m_ptr     = (g + 1) % NCH;
            m_pend[g] = 1'b0;
        end else if (load) begin
            m_valid = 1'b0;
        end
        if (bus.ovf_clr) m_ovf = '0;
        for (int c = 0; c < NCH; c++) begin
            if (vio[c]) begin
                if (m_pend[c]) m_ovf[c] = 1'b1;
                else begin
                    m_pend[c] = 1'b1;
                    m_slot[c] = nrep[c];
                end
            end
            if (bus.dat_ev[c]) m_lastdat[c] = cyc;
            if (bus.ref_ev[c]) m_lastref[c] = cyc;
        end
        if (bus.cfg_we) begin
            if (bus.cfg_kind) m_hlim[bus.cfg_ch] = int'(bus.cfg_limit);
            else              m_slim[bus.cfg_ch] = int'(bus.cfg_limit);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: advance the model, take the edge, compare every output.
    task automatic tick();
        if (!rst && bus.vio_valid && bus.vio_ready)
            $display("[cyc %0d] report accepted ch=%0d kind=%0d delta=%0d",
                     cyc, bus.vio_ch, bus.vio_kind, bus.vio_delta);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        chk("valid", 32'(bus.vio_valid), 32'(m_valid));
        chk("ch",    32'(bus.vio_ch),    32'(m_out.ch));
        chk("kind",  32'(bus.vio_kind),  32'(m_out.kind));
        chk("delta", 32'(bus.vio_delta), 32'(m_out.delta));
        chk("ovf",   32'(bus.ovf),       32'(m_ovf));
    endtask

    task automatic idle();
        bus.ref_ev    = '0;
        bus.dat_ev    = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_kind  = 1'b0;
        bus.cfg_limit = '0;
        bus.ovf_clr   = 1'b0;
    endtask

    task automatic cfg(input int ch, input bit kind, input int lim);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_kind  = kind;
        bus.cfg_limit = 8'(lim);
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic pulse(input logic [NCH-1:0] r, input logic [NCH-1:0] d);
        bus.ref_ev = r;
        bus.dat_ev = d;
        tick();
        bus.ref_ev = '0;
        bus.dat_ev = '0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        bus.vio_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(bus.vio_valid), 32'd0);
        chk("rst_delta", 32'(bus.vio_delta), 32'd0);
        chk("rst_ovf",   32'(bus.ovf),       32'd0);
        cyc = 0;

        // Limits: ch0 setup 5, ch1 hold 4, ch2 setup 1 / hold 3
        cfg(0, 1'b0, 5);
        cfg(1, 1'b1, 4);
        cfg(2, 1'b0, 1);
        cfg(2, 1'b1, 3);

        // Setup: dat@10, ref@13 -> {0,SETUP,3} valid at 15
        run_to(10); pulse(4'b0000, 4'b0001);
        run_to(13); pulse(4'b0001, 4'b0000);
        chk("setup_latency", 32'(bus.vio_valid), 32'd0);
        tick();
        chk("setup_valid", 32'(bus.vio_valid), 32'd1);
        chk("setup_ch",    32'(bus.vio_ch),    32'd0);
        chk("setup_kind",  32'(bus.vio_kind),  32'd0);
        chk("setup_delta", 32'(bus.vio_delta), 32'd3);

        // Hold: ref@20, dat@23 -> {1,HOLD,3}; dat@25 outside window
        run_to(20); pulse(4'b0010, 4'b0000);
        run_to(23); pulse(4'b0000, 4'b0010);
        tick();
        chk("hold_valid", 32'(bus.vio_valid), 32'd1);
        chk("hold_ch",    32'(bus.vio_ch),    32'd1);
        chk("hold_kind",  32'(bus.vio_kind),  32'd1);
        chk("hold_delta", 32'(bus.vio_delta), 32'd3);
        run_to(25); pulse(4'b0000, 4'b0010);
        tick();
        chk("hold_closed", 32'(bus.vio_valid), 32'd0);

        // Coincident ref/dat -> one SETUP with delta 0, no HOLD
        run_to(30); pulse(4'b0100, 4'b0100);
        tick();
        chk("coinc_valid", 32'(bus.vio_valid), 32'd1);
        chk("coinc_ch",    32'(bus.vio_ch),    32'd2);
        chk("coinc_kind",  32'(bus.vio_kind),  32'd0);
        chk("coinc_delta", 32'(bus.vio_delta), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("coinc_single", 32'(bus.vio_valid), 32'd0);
        end

        // Arbitration under backpressure, pointer starts at 0 after reset
        do_reset();
        for (int c = 0; c < NCH; c++) cfg(c, 1'b0, 1);
        bus.vio_ready = 1'b0;
        pulse(4'b1111, 4'b1111);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("arb_hold_valid", 32'(bus.vio_valid), 32'd1);
            chk("arb_hold_ch",    32'(bus.vio_ch),    32'd0);
            tick();
        end
        chk("arb_first_ch", 32'(bus.vio_ch), 32'd0);
        bus.vio_ready = 1'b1;
        for (int k = 1; k < NCH; k++) begin
            tick();
            chk("arb_order_valid", 32'(bus.vio_valid), 32'd1);
            chk("arb_order_ch",    32'(bus.vio_ch),    32'(k));
        end
        tick();
        chk("arb_drained", 32'(bus.vio_valid), 32'd0);
        chk("arb_no_ovf",  32'(bus.ovf),       32'd0);

        // Overflow: output held by ch0, ch3 violates twice (deltas 3 then 4)
        bus.vio_ready = 1'b0;
        cfg(3, 1'b0, 10);
        pulse(4'b0001, 4'b1001);
        tick();
        tick();
        pulse(4'b1000, 4'b0000);
        pulse(4'b1000, 4'b0000);
        chk("ovf_set",    32'(bus.ovf),    32'h8);
        chk("ovf_out_ch", 32'(bus.vio_ch), 32'd0);
        bus.vio_ready = 1'b1;
        tick();
        chk("ovf_first_ch",    32'(bus.vio_ch),    32'd3);
        chk("ovf_first_delta", 32'(bus.vio_delta), 32'd3);
        tick();
        chk("ovf_only_one", 32'(bus.vio_valid), 32'd0);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(bus.ovf), 32'd0);

        // Reset while a report is presented and slots are pending
        bus.vio_ready = 1'b0;
        pulse(4'b1111, 4'b1111);
        tick();
        chk("midrst_busy", 32'(bus.vio_valid), 32'd1);
        bus.vio_ready = 1'b1;
        do_reset();
        chk("midrst_valid", 32'(bus.vio_valid), 32'd0);
        chk("midrst_ch",    32'(bus.vio_ch),    32'd0);
        chk("midrst_delta", 32'(bus.vio_delta), 32'd0);
        chk("midrst_ovf",   32'(bus.ovf),       32'd0);
        pulse(4'b1111, 4'b1111);
        pulse(4'b0000, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("midrst_silent", 32'(bus.vio_valid), 32'd0);
        end

        // Random traffic with fixed random limits
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            cfg(c, 1'b0, $urandom_range(0, 8));
            cfg(c, 1'b1, $urandom_range(0, 6));
        end
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                bus.ref_ev[c] = ($urandom_range(0, 4) == 0);
                bus.dat_ev[c] = ($urandom_range(0, 4) == 0);
            end
            bus.vio_ready = ($urandom_range(0, 3) != 0);
            bus.ovf_clr   = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle();
        bus.vio_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
